// File: rtl/load_fmt_queue.sv
// Load-result formatting stage: queues load descriptors at issue, pairs them in order
// with memory responses, and emits aligned/extended/merged write-back data.
`timescale 1ns/1ps
module load_fmt_queue #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [OFF_W-1:0]  req_off,
    input  logic [DATA_W-1:0] req_rt,
    input  logic [4:0]        req_wreg,
    output logic              req_reject,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              wb_valid,
    output logic [4:0]        wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              err_orphan
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [3:0] OP_LB  = 4'd0, OP_LBU = 4'd1, OP_LH  = 4'd2,
                           OP_LHU = 4'd3, OP_LW  = 4'd4, OP_LWU = 4'd5,
                           OP_LD  = 4'd6, OP_LWL = 4'd7, OP_LWR = 4'd8;

    typedef struct packed {
        logic [3:0]        op;
        logic [OFF_W-1:0]  off;
        logic [DATA_W-1:0] rt;
        logic [4:0]        wreg;
    } desc_t;

    desc_t             fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]  count_q, count_d, drop_q, drop_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_wreg_q, wb_wreg_d;
    logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
    logic              orphan_q, orphan_d;
    logic [CNT_W:0]    outstanding;
    logic              enq, rsp_drop, rsp_pop, rsp_orph;
    desc_t             head;

    function automatic logic [DATA_W-1:0] fmt_load(input desc_t d, input logic [DATA_W-1:0] data);
        logic [31:0]      sh, w, rt32, r32;
        logic [OFF_W-1:0] woff;
        logic [5:0]       k8;
        sh   = 32'(data >> {d.off, 3'b000});
        woff = d.off & ~OFF_W'(3);
        w    = 32'(data >> {woff, 3'b000});
        rt32 = d.rt[31:0];
        k8   = {1'b0, d.off[1:0], 3'b000};
        r32  = w;
        fmt_load = data;
        case (d.op)
            OP_LB:  fmt_load = DATA_W'($signed(sh[7:0]));
            OP_LBU: fmt_load = DATA_W'(sh[7:0]);
            OP_LH:  fmt_load = DATA_W'($signed(sh[15:0]));
            OP_LHU: fmt_load = DATA_W'(sh[15:0]);
            OP_LW:  fmt_load = DATA_W'($signed(sh));
            OP_LWU: fmt_load = DATA_W'(sh);
            OP_LWL: begin
                // Word bytes fill from the top; rt keeps the low bytes not covered.
                r32 = (w << (6'd24 - k8)) | (rt32 & (32'hFFFF_FFFF >> (k8 + 6'd8)));
                fmt_load = DATA_W'($signed(r32));
            end
            OP_LWR: begin
                r32 = (w >> k8) | (rt32 & ~(32'hFFFF_FFFF >> k8));
                fmt_load = DATA_W'($signed(r32));
            end
            default: fmt_load = data;
        endcase
    endfunction

    always_comb begin
        req_reject = 1'b0;
        case (req_op)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: req_reject = 1'b0;
            OP_LH, OP_LHU: req_reject = req_off[0];
            OP_LW:         req_reject = (req_off[1:0] != 2'b00);
            OP_LWU:        req_reject = (DATA_W == 32) || (req_off[1:0] != 2'b00);
            OP_LD:         req_reject = (DATA_W == 32) || (req_off != '0);
            default:       req_reject = 1'b1;
        endcase
    end

    assign outstanding = (CNT_W+1)'(count_q) + (CNT_W+1)'(drop_q);
    assign req_ready   = !flush && (outstanding < (CNT_W+1)'(DEPTH));
    assign enq         = req_valid && req_ready && !req_reject;
    assign rsp_drop    = rsp_valid && (drop_q != '0);
    assign rsp_pop     = rsp_valid && (drop_q == '0) && (count_q != '0);
    assign rsp_orph    = rsp_valid && (drop_q == '0) && (count_q == '0);
    assign head        = fifo_q[rd_q];

    always_comb begin
        wr_d       = enq ? wr_q + PTR_W'(1) : wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        drop_d     = drop_q;
        wb_valid_d = 1'b0;
        wb_wreg_d  = wb_wreg_q;
        wb_wdata_d = wb_wdata_q;
        orphan_d   = orphan_q | rsp_orph;
        if (flush) begin
            // A response consumed this cycle is always discarded; queued entries become drops.
            drop_d  = drop_q + count_q - CNT_W'(rsp_pop) - CNT_W'(rsp_drop);
            count_d = '0;
            rd_d    = wr_q;
        end else begin
            drop_d  = drop_q - CNT_W'(rsp_drop);
            count_d = count_q + CNT_W'(enq) - CNT_W'(rsp_pop);
            if (rsp_pop) begin
                rd_d       = rd_q + PTR_W'(1);
                wb_valid_d = 1'b1;
                wb_wreg_d  = head.wreg;
                wb_wdata_d = fmt_load(head, rsp_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) fifo_q[wr_q] <= {req_op, req_off, req_rt, req_wreg};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_wreg_q  <= '0;
            wb_wdata_q <= '0;
            orphan_q   <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            wb_valid_q <= wb_valid_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            orphan_q   <= orphan_d;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_wreg    = wb_wreg_q;
    assign wb_wdata   = wb_wdata_q;
    assign err_orphan = orphan_q;

endmodule

// File: tb/tb_load_fmt_queue.sv
// Scoreboard bench for load_fmt_queue: one 32-bit and one 64-bit instance share the payload
// bus, each with its own valid strobes and an expected write-back queue.
`timescale 1ns/1ps
module tb_load_fmt_queue;

    typedef struct {
        logic [4:0]  wreg;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush32, flush64;
    logic        rv32, rv64, sv32, sv64;
    logic [3:0]  op;
    logic [2:0]  off;
    logic [63:0] rt, rdata;
    logic [4:0]  wreg;

    logic        rdy32, rej32, wbv32, orph32;
    logic [4:0]  wbr32;
    logic [31:0] wbd32;
    logic        rdy64, rej64, wbv64, orph64;
    logic [4:0]  wbr64;
    logic [63:0] wbd64;

    exp_t q32[$];
    exp_t q64[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    load_fmt_queue #(.DATA_W(32), .DEPTH(4)) u32 (
        .clk(clk), .resetn(resetn), .flush(flush32),
        .req_valid(rv32), .req_ready(rdy32), .req_op(op), .req_off(off[1:0]),
        .req_rt(rt[31:0]), .req_wreg(wreg), .req_reject(rej32),
        .rsp_valid(sv32), .rsp_data(rdata[31:0]),
        .wb_valid(wbv32), .wb_wreg(wbr32), .wb_wdata(wbd32), .err_orphan(orph32)
    );

    load_fmt_queue #(.DATA_W(64), .DEPTH(4)) u64 (
        .clk(clk), .resetn(resetn), .flush(flush64),
        .req_valid(rv64), .req_ready(rdy64), .req_op(op), .req_off(off),
        .req_rt(rt), .req_wreg(wreg), .req_reject(rej64),
        .rsp_valid(sv64), .rsp_data(rdata),
        .wb_valid(wbv64), .wb_wreg(wbr64), .wb_wdata(wbd64), .err_orphan(orph64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference formatting for the 32-bit instance, built byte by byte.
    function automatic logic [31:0] model32(input logic [3:0] o, input logic [1:0] f,
                                            input logic [31:0] r, input logic [31:0] d);
        logic [7:0]  b[4], rb[4], ob[4];
        logic [31:0] res;
        int          k;
        k = int'(f);
        for (int i = 0; i < 4; i++) begin
            b[i]  = d[8*i +: 8];
            rb[i] = r[8*i +: 8];
        end
        res = 32'h0;
        case (o)
            4'd0: res = {{24{b[k][7]}}, b[k]};
            4'd1: res = {24'h0, b[k]};
            4'd2: res = {{16{b[k+1][7]}}, b[k+1], b[k]};
            4'd3: res = {16'h0, b[k+1], b[k]};
            4'd4: res = d;
            4'd7: begin
                for (int j = 0; j < 4; j++) ob[j] = (j >= 3 - k) ? b[j - (3 - k)] : rb[j];
                res = {ob[3], ob[2], ob[1], ob[0]};
            end
            4'd8: begin
                for (int j = 0; j < 4; j++) ob[j] = (j + k <= 3) ? b[j + k] : rb[j];
                res = {ob[3], ob[2], ob[1], ob[0]};
            end
            default: res = 32'hDEAD_BEEF;
        endcase
        return res;
    endfunction

    task automatic issue(input bit w64, input logic [3:0] o, input logic [2:0] f,
                         input logic [63:0] r, input logic [4:0] wr,
                         input bit exp_rej, input bit exp_wb, input logic [63:0] exp);
        exp_t e;
        op = o; off = f; rt = r; wreg = wr;
        if (w64) rv64 = 1'b1; else rv32 = 1'b1;
        #2;
        chk("req_ready", w64 ? rdy64 : rdy32, 1'b1);
        chk("req_reject", w64 ? rej64 : rej32, exp_rej);
        if (!exp_rej && exp_wb) begin
            e.wreg = wr;
            e.data = exp;
            if (w64) q64.push_back(e); else q32.push_back(e);
        end
        @(posedge clk); #1;
        rv32 = 1'b0; rv64 = 1'b0;
    endtask

    task automatic resp(input bit w64, input logic [63:0] d);
        rdata = d;
        if (w64) sv64 = 1'b1; else sv32 = 1'b1;
        @(posedge clk); #1;
        sv32 = 1'b0; sv64 = 1'b0;
    endtask

    always @(negedge clk) begin : mon32
        exp_t e;
        if (wbv32) begin
            if (q32.size() == 0) chk("wb32_unexpected", 1'b1, 1'b0);
            else begin
                e = q32.pop_front();
                chk("wb32_wreg", wbr32, e.wreg);
                chk("wb32_data", wbd32, e.data);
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        if (wbv64) begin
            if (q64.size() == 0) chk("wb64_unexpected", 1'b1, 1'b0);
            else begin
                e = q64.pop_front();
                chk("wb64_wreg", wbr64, e.wreg);
                chk("wb64_data", wbd64, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  ops[7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
        logic [3:0]  o;
        logic [2:0]  f;
        logic [31:0] r, d;

        resetn = 1'b0; flush32 = 1'b0; flush64 = 1'b0;
        rv32 = 1'b0; rv64 = 1'b0; sv32 = 1'b0; sv64 = 1'b0;
        op = '0; off = '0; rt = '0; rdata = '0; wreg = '0;
        #3;
        chk("rst_wb_valid32", wbv32, 1'b0);
        chk("rst_wb_wdata32", wbd32, 32'h0);
        chk("rst_wb_wreg32", wbr32, 5'd0);
        chk("rst_orphan32", orph32, 1'b0);
        chk("rst_wb_wdata64", wbd64, 64'h0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // Byte loads, signed and unsigned
        issue(0, 4'd0, 3'd2, 64'h0, 5'd1, 0, 1, 64'hFFFF_FFF4);
        resp(0, 64'h12F4_5678);
        issue(0, 4'd1, 3'd2, 64'h0, 5'd2, 0, 1, 64'h0000_00F4);
        resp(0, 64'h12F4_5678);

        // Unaligned merges
        issue(0, 4'd7, 3'd1, 64'hAABB_CCDD, 5'd3, 0, 1, 64'h3344_CCDD);
        issue(0, 4'd8, 3'd1, 64'hAABB_CCDD, 5'd4, 0, 1, 64'hAA11_2233);
        resp(0, 64'h1122_3344);
        resp(0, 64'h1122_3344);

        // Fill all four slots, then check back-pressure release timing
        for (int i = 0; i < 4; i++)
            issue(0, 4'd4, 3'd0, 64'h0, 5'(10 + i), 0, 1, 64'hC0DE_0000 + 64'(i));
        chk("full_ready", rdy32, 1'b0);
        rdata = 64'hC0DE_0000; sv32 = 1'b1;
        #2;
        chk("full_ready_same_cycle_rsp", rdy32, 1'b0);
        @(posedge clk); #1; sv32 = 1'b0;
        chk("ready_after_rsp", rdy32, 1'b1);
        for (int i = 1; i < 4; i++) resp(0, 64'hC0DE_0000 + 64'(i));

        // Flush with a simultaneous pop-eligible response leaves one drop pending
        issue(0, 4'd4, 3'd0, 64'h0, 5'd20, 0, 1, 64'h2020_2020);
        issue(0, 4'd4, 3'd0, 64'h0, 5'd21, 0, 0, 64'h0);
        issue(0, 4'd4, 3'd0, 64'h0, 5'd22, 0, 0, 64'h0);
        resp(0, 64'h2020_2020);
        flush32 = 1'b1; rdata = 64'h5151_5151; sv32 = 1'b1;
        #2;
        chk("flush_ready", rdy32, 1'b0);
        @(posedge clk); #1; flush32 = 1'b0; sv32 = 1'b0;
        issue(0, 4'd4, 3'd0, 64'h0, 5'd7, 0, 1, 64'h7777_7777);
        resp(0, 64'h5252_5252);
        resp(0, 64'h7777_7777);
        chk("flush_no_orphan", orph32, 1'b0);

        // Illegal / misaligned descriptors must not occupy a slot
        issue(0, 4'd2, 3'd1, 64'h0, 5'd30, 1, 0, 64'h0);
        issue(0, 4'd6, 3'd0, 64'h0, 5'd30, 1, 0, 64'h0);
        issue(0, 4'd9, 3'd0, 64'h0, 5'd30, 1, 0, 64'h0);
        issue(0, 4'd4, 3'd2, 64'h0, 5'd30, 1, 0, 64'h0);
        issue(0, 4'd5, 3'd0, 64'h0, 5'd30, 1, 0, 64'h0);
        issue(0, 4'd4, 3'd0, 64'h0, 5'd5, 0, 1, 64'h5555_AAAA);
        resp(0, 64'h5555_AAAA);
        chk("reject_no_orphan", orph32, 1'b0);

        // Random legal loads against the byte-level model
        for (int it = 0; it < 24; it++) begin
            o = ops[$urandom_range(0, 6)];
            case (o)
                4'd2, 4'd3: f = 3'($urandom_range(0, 1) * 2);
                4'd4:       f = 3'd0;
                default:    f = 3'($urandom_range(0, 3));
            endcase
            r = $urandom;
            d = $urandom;
            issue(0, o, f, 64'(r), 5'(it), 0, 1, 64'(model32(o, f[1:0], r, d)));
            resp(0, 64'(d));
        end

        // 64-bit datapath
        issue(1, 4'd4, 3'd4, 64'h0, 5'd1, 0, 1, 64'hFFFF_FFFF_8000_0001);
        resp(1, 64'h8000_0001_0000_0000);
        issue(1, 4'd6, 3'd0, 64'h0, 5'd2, 0, 1, 64'h0123_4567_89AB_CDEF);
        resp(1, 64'h0123_4567_89AB_CDEF);
        issue(1, 4'd6, 3'd4, 64'h0, 5'd9, 1, 0, 64'h0);
        issue(1, 4'd8, 3'd4, 64'hAABB_CCDD, 5'd3, 0, 1, 64'hFFFF_FFFF_8122_3344);
        resp(1, 64'h8122_3344_5566_7788);
        issue(1, 4'd7, 3'd5, 64'hAABB_CCDD, 5'd4, 0, 1, 64'h0000_0000_3344_CCDD);
        resp(1, 64'h8122_3344_5566_7788);
        issue(1, 4'd5, 3'd4, 64'h0, 5'd5, 0, 1, 64'h0000_0000_8122_3344);
        resp(1, 64'h8122_3344_5566_7788);
        issue(1, 4'd0, 3'd7, 64'h0, 5'd6, 0, 1, 64'hFFFF_FFFF_FFFF_FF81);
        resp(1, 64'h8122_3344_5566_7788);
        chk("orphan64_clear", orph64, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb32_drained", 64'(q32.size()), 64'd0);
        chk("sb64_drained", 64'(q64.size()), 64'd0);

        // Orphan response is sticky until reset
        resp(0, 64'h0BAD_0BAD);
        chk("orphan_set", orph32, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("orphan_sticky", orph32, 1'b1);
        resetn = 1'b0;
        #1;
        chk("orphan_reset", orph32, 1'b0);
        chk("wb_wdata_reset", wbd32, 32'h0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", rdy32, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_fmt_queue.md
Name: load_fmt_queue

Overview:
Parametrised load-result formatting stage between the data-memory response path and register write-back. It queues load descriptors at issue and pairs each with its in-order memory response. Each result is aligned, extended or merged (LWL/LWR merge with the old rt value) and emitted as a registered write-back. The block supports 32- or 64-bit datapaths, variable memory latency, pipeline flush with discard of in-flight responses, and rejection of illegal or misaligned loads.

Parameters:
DATA_W, 32, datapath width; legal values are 32 and 64.
DEPTH, 4, maximum number of outstanding loads; must be a power of 2 and at least 2.
OFF_W, derived as log2(DATA_W/8), byte-offset width (2 or 3). Not user-set.

Ports:
clk  in  1  clock; all state updates on the rising edge.
resetn  in  1  asynchronous, active-low reset.
flush  in  1  pipeline flush; discards all queued descriptors.
req_valid  in  1  load descriptor presented.
req_ready  out  1  descriptor can be accepted.
req_op  in  4  load op: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWU, 6 LD, 7 LWL, 8 LWR; 9-15 reserved.
req_off  in  OFF_W  low address bits.
req_rt  in  DATA_W  old destination value, used for LWL/LWR merge.
req_wreg  in  5  destination register.
req_reject  out  1  combinational; current descriptor is illegal or misaligned.
rsp_valid  in  1  memory read data valid; cannot be back-pressured.
rsp_data  in  DATA_W  aligned memory word.
wb_valid  out  1  write-back strobe.
wb_wreg  out  5  write-back destination.
wb_wdata  out  DATA_W  formatted result.
err_orphan  out  1  sticky; a response arrived with nothing outstanding.

Behaviour:
- Reset (resetn=0, asynchronous): FIFO empty, drop_cnt=0, wb_valid=0, wb_wreg=0, wb_wdata=0, err_orphan=0. Reset asserted mid-operation abandons all in-flight state immediately.
- outstanding = count + drop_cnt, and is always <= DEPTH.
- req_ready = !flush && (outstanding < DEPTH).
- Request handshake completes when req_valid && req_ready.
- req_reject=1 conditions:
  - reserved op;
  - LWU or LD when DATA_W=32;
  - LH/LHU with off[0]!=0;
  - LW/LWU with off[1:0]!=0;
  - LD with off!=0.
- A rejected descriptor still completes the handshake but is not enqueued; no memory response is expected for it.
- Enqueue stores {op, off, rt, wreg}. Responses match descriptors in strict FIFO order. Memory latency is at least 1 cycle, so a response never pairs with a descriptor enqueued in the same cycle.
- On rsp_valid, resolved in priority order:
  - if drop_cnt>0: decrement drop_cnt, discard the data;
  - else if count>0: pop the head, format, register the result;
  - else: set err_orphan and discard.
- Output latency: wb_valid=1 exactly one cycle after a popped response; wb_wreg and wb_wdata are registered with it. Otherwise wb_valid=0 and wb_wdata/wb_wreg hold their last value.
- Flush: drop_cnt <= drop_cnt + count and count <= 0.
  - Flush in the same cycle as a pop-eligible response: that response is discarded, so the new drop_cnt = old drop_cnt + count - 1.
  - Flush in the same cycle as a response taken while drop_cnt>0: that response is counted against the old drop_cnt, so the new drop_cnt = old drop_cnt - 1 + count.
  - No wb_valid results from a response consumed in a flush cycle.
- Requests accepted after a flush queue normally. The drop_cnt responses drain first because memory returns in order.
- Formatting (byte k = bits 8k+7:8k, little-endian):
  - LB/LBU: byte[off], sign-/zero-extended to DATA_W.
  - LH/LHU: halfword at off, sign-/zero-extended.
  - LW/LWU: word at off, sign-/zero-extended (LW on DATA_W=32 is a plain copy).
  - LD: rsp_data unchanged.
  - LWL, with w = 32-bit word selected by off[OFF_W-1] when DATA_W=64 (w = rsp_data when DATA_W=32), k = off[1:0], n = 8(k+1): result32 = {w[n-1:0], rt[31-n:0]}; k=3 gives w.
  - LWR, with w and k as for LWL: result32 = {rt[31:32-8k], w[31:8k]}; k=0 gives w.
  - For DATA_W=64, LWL/LWR results are sign-extended from bit 31.
- The FIFO read/write pointers wrap modulo DEPTH. When outstanding=DEPTH, req_ready=0 until a response arrives; a response in the same cycle frees a slot for the next cycle only.

Test Plan:
- DATA_W=32: enqueue LB off=2, then rsp_data=0x12F45678 -> one cycle later wb_valid=1, wb_wdata=0xFFFFFFF4; LBU on the same data -> 0x000000F4.
- LWL off=1 with rt=0xAABBCCDD, rsp=0x11223344 -> 0x3344CCDD; LWR off=1, same rt and rsp -> 0xAA112233.
- DEPTH=4: enqueue 4 LW without responses -> req_ready=0 on the 5th; a response in the next cycle -> req_ready=1 one cycle later; 4 responses -> 4 wb_valid pulses with wreg in issue order.
- Enqueue 3 loads, return 1 response, flush with a simultaneous response -> drop_cnt=1; enqueue LW wreg=7; next 2 responses -> the first is dropped, the second writes wreg=7; err_orphan stays 0.
- LH off=1 -> req_reject=1, count unchanged; with DATA_W=32, LD -> req_reject=1; rsp_valid with the FIFO empty and drop_cnt=0 -> err_orphan=1 and sticky until reset.
- DATA_W=64: LW off=4, rsp=0x80000001_00000000 -> 0xFFFFFFFF80000001; LD off=0 -> the data passes through unchanged.
